// File: rtl/seq_signed_divider_pkg.sv
// Shared arithmetic helpers and types for the sequential signed divider.
// The magnitude helpers work on wide vectors so callers of any width can size-cast in and out.
package seq_signed_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEF_DIVIDEND_W = 5;
    localparam int DEF_DIVISOR_W  = 3;
    localparam int MAX_W          = 64;

    // Input must already be sign-extended to MAX_W so the top bit is the true sign.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] v);
        return v[MAX_W-1] ? -v : v;
    endfunction

    function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v,
                                                     input logic             neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/seq_signed_divider_restore_step.sv
// One restoring-division step: shift in a dividend bit, subtract |divisor| when it fits.
// The kept remainder is always below |divisor|, so it fits back into DIVISOR_W bits.
module div_restore_step #(
    parameter int DIVISOR_W = 3
) (
    input  logic [DIVISOR_W-1:0] p_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] dsr,
    output logic [DIVISOR_W-1:0] p_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;

    always_comb begin
        shifted = {p_in, bit_in};
        diff    = shifted - {1'b0, dsr};
        q_bit   = (shifted >= {1'b0, dsr});
        p_out   = q_bit ? DIVISOR_W'(diff) : DIVISOR_W'(shifted);
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed restoring divider: magnitudes in, one quotient bit per clock,
// sign correction on the way out, valid/ready on both sides.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DIVIDEND_W-1:0] quotient,
    output logic signed [DIVISOR_W-1:0]  remainder,
    output logic                         div_by_zero,
    output logic                         overflow
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]  dvd_q, dvd_d;      // dividend magnitude, shifts out MSB / in quotient bits
    logic [DIVISOR_W-1:0]   dsr_q, dsr_d;
    logic [DIVISOR_W-1:0]   p_q, p_d;
    logic [DIVISOR_W-1:0]   dvd_lo_q, dvd_lo_d;
    logic                   sd_q, sd_d;
    logic                   ss_q, ss_d;
    logic                   dbz_q, dbz_d;
    logic                   ovf_q, ovf_d;
    logic [DIVIDEND_W-1:0]  quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]   remainder_q, remainder_d;

    logic [DIVISOR_W-1:0]   step_p;
    logic                   step_q;

    div_restore_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .p_in  (p_q),
        .bit_in(dvd_q[DIVIDEND_W-1]),
        .dsr   (dsr_q),
        .p_out (step_p),
        .q_bit (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        p_d         = p_q;
        dvd_lo_d    = dvd_lo_q;
        sd_d        = sd_q;
        ss_d        = ss_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = CALC;
                    cnt_d       = CNT_W'(DIVIDEND_W);
                    dvd_d       = DIVIDEND_W'(abs_mag(MAX_W'(dividend)));
                    dsr_d       = DIVISOR_W'(abs_mag(MAX_W'(divisor)));
                    p_d         = '0;
                    dvd_lo_d    = dividend[DIVISOR_W-1:0];
                    sd_d        = dividend[DIVIDEND_W-1];
                    ss_d        = divisor[DIVISOR_W-1];
                    dbz_d       = (divisor == '0);
                    ovf_d       = dividend[DIVIDEND_W-1] && (dividend[DIVIDEND_W-2:0] == '0)
                                  && (&divisor);
                    quotient_d  = '0;
                    remainder_d = '0;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    p_d   = step_p;
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Magnitude result is complete; sign-correct once on the way to DONE.
                    // The overflow case needs no special path: 2^(N-1) wraps to -2^(N-1).
                    state_d = DONE;
                    if (dbz_q) begin
                        quotient_d  = '1;
                        remainder_d = dvd_lo_q;
                    end else begin
                        quotient_d  = DIVIDEND_W'(cond_negate(MAX_W'(dvd_q), sd_q ^ ss_q));
                        remainder_d = DIVISOR_W'(cond_negate(MAX_W'(p_q), sd_q));
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            p_q         <= '0;
            dvd_lo_q    <= '0;
            sd_q        <= 1'b0;
            ss_q        <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            p_q         <= p_d;
            dvd_lo_q    <= dvd_lo_d;
            sd_q        <= sd_d;
            ss_q        <= ss_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed-vector bench for seq_signed_divider at the default 5/3 widths.
module tb_seq_signed_divider;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [4:0] dividend;
    logic signed [2:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic signed [4:0] quotient;
    logic signed [2:0] remainder;
    logic              div_by_zero;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_signed_divider #(
        .DIVIDEND_W(5),
        .DIVISOR_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [4:0] a, input logic [2:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== 10'b0) begin
            n_fail++; $display("FAIL reset_outputs got q=%b r=%b dz=%b ov=%b want all 0", quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        start_op(5'b01101, 3'b011);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_ready got %b want 0", in_ready); end
        wait_result(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency got %0d want 6", lat); end
        n_checks++; if (quotient !== 5'b00100) begin n_fail++; $display("FAIL basic_quotient got %b want 00100", quotient); end
        n_checks++; if (remainder !== 3'b001) begin n_fail++; $display("FAIL basic_remainder got %b want 001", remainder); end
        n_checks++; if ({div_by_zero, overflow} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b want 00", {div_by_zero, overflow}); end
        consume();
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL basic_handoff got rdy/vld %b want 10", {in_ready, out_valid}); end
    endtask

    task automatic test_signs();
        int lat;
        start_op(5'b10011, 3'b011);
        wait_result(lat);
        n_checks++; if (quotient !== 5'b11100) begin n_fail++; $display("FAIL negdvd_quotient got %b want 11100", quotient); end
        n_checks++; if (remainder !== 3'b111) begin n_fail++; $display("FAIL negdvd_remainder got %b want 111", remainder); end
        consume();
        start_op(5'b01101, 3'b101);
        wait_result(lat);
        n_checks++; if (quotient !== 5'b11100) begin n_fail++; $display("FAIL negdsr_quotient got %b want 11100", quotient); end
        n_checks++; if (remainder !== 3'b001) begin n_fail++; $display("FAIL negdsr_remainder got %b want 001", remainder); end
        consume();
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(5'b01001, 3'b000);
        wait_result(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL dz_latency got %0d want 6", lat); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL dz_overflow got %b want 0", overflow); end
        n_checks++; if (quotient !== 5'b11111) begin n_fail++; $display("FAIL dz_quotient got %b want 11111", quotient); end
        n_checks++; if (remainder !== 3'b001) begin n_fail++; $display("FAIL dz_remainder got %b want 001", remainder); end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(5'b10000, 3'b111);
        wait_result(lat);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ov_flag got %b want 1", overflow); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ov_dz got %b want 0", div_by_zero); end
        n_checks++; if (quotient !== 5'b10000) begin n_fail++; $display("FAIL ov_quotient got %b want 10000", quotient); end
        n_checks++; if (remainder !== 3'b000) begin n_fail++; $display("FAIL ov_remainder got %b want 000", remainder); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(5'b00111, 3'b010);
        wait_result(lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dividend = 5'b01111;
            divisor  = 3'b001;
            in_valid = c[0];
            @(posedge clk);
            #1;
            n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_%0d got vld/rdy %b want 10", c, {out_valid, in_ready}); end
            n_checks++; if ({quotient, remainder} !== {5'b00011, 3'b001}) begin
                n_fail++; $display("FAIL bp_data_%0d got q=%b r=%b want 00011 001", c, quotient, remainder);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release got rdy/vld %b want 10", {in_ready, out_valid}); end
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_queue got in_ready %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        start_op(5'b11001, 3'b010);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL midrst_ctrl got rdy/vld %b want 10", {in_ready, out_valid}); end
        n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== 10'b0) begin
            n_fail++; $display("FAIL midrst_outputs got q=%b r=%b want 0", quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(5'b11001, 3'b010);
        wait_result(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL midrst_latency got %0d want 6", lat); end
        n_checks++; if (quotient !== 5'b11101) begin n_fail++; $display("FAIL midrst_quotient got %b want 11101", quotient); end
        n_checks++; if (remainder !== 3'b111) begin n_fail++; $display("FAIL midrst_remainder got %b want 111", remainder); end
        consume();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
